// File: rtl/periph_bus_ctrl.sv
// Peripheral bus sequencer: decodes core data-memory requests to one chip-enable and runs a setup/access transfer.
// Optional ACCESS-phase timeout is enabled by defining PERIPH_BUS_TIMEOUT_EN.
module periph_bus_ctrl #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
  parameter int unsigned SLOT_BITS      = 12,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    transfer,
  input  logic                    write,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    ready,
  output logic                    err,
  output logic [3:0]              p_addr,
  output logic                    p_wr_en,
  output logic [31:0]             p_wdata,
  output logic                    p_enable,
  output logic [NUM_SLAVES-1:0]   p_ce,
  input  logic [32*NUM_SLAVES-1:0] p_rdata,
  input  logic [NUM_SLAVES-1:0]   p_ready
);

  localparam int unsigned SEL_W   = 3;
  localparam int unsigned TAG_LSB = SLOT_BITS + 3;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERROR} state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q;
  logic              write_q;
  logic [3:0]        addr_q;
  logic [31:0]       wdata_q;

  logic [SEL_W-1:0]  slot_c;
  logic              hit_c;
  logic              sel_ready_c;
  logic [31:0]       sel_rdata_c;
  logic              timeout_c;
  logic              unused_addr_c;

  // Window tag match plus populated-slot check.
  assign slot_c        = addr[SLOT_BITS+2:SLOT_BITS];
  assign hit_c         = (addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]) &&
                         ({1'b0, slot_c} < 4'(NUM_SLAVES));
  assign unused_addr_c = ^{addr[1:0], addr[SLOT_BITS-1:6]};

  // Only the latched slave's ready/rdata are ever looked at.
  always_comb begin
    sel_ready_c = 1'b0;
    sel_rdata_c = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q == SEL_W'(i)) begin
        sel_ready_c = p_ready[i];
        sel_rdata_c = p_rdata[32*i +: 32];
      end
    end
  end

`ifdef PERIPH_BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counts stalled ACCESS cycles; held at zero outside ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q != ACCESS) begin
      cnt_q <= '0;
    end else if (!sel_ready_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`else
  localparam int unsigned unused_timeout = TIMEOUT_CYCLES;

  assign timeout_c = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && transfer && hit_c) begin
        sel_q   <= slot_c;
        write_q <= write;
        addr_q  <= addr[5:2];
        wdata_q <= wdata;
      end
    end
  end

  assign p_addr  = addr_q;
  assign p_wdata = wdata_q;

  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    err      = 1'b0;
    rdata    = '0;
    p_ce     = '0;
    p_enable = 1'b0;
    p_wr_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (transfer) state_d = hit_c ? SETUP : ERROR;
      end
      SETUP: begin
        p_ce    = NUM_SLAVES'(1) << sel_q;
        p_wr_en = write_q;
        state_d = ACCESS;
      end
      ACCESS: begin
        p_ce     = NUM_SLAVES'(1) << sel_q;
        p_enable = 1'b1;
        p_wr_en  = write_q;
        // A slave ready in the final timeout cycle still completes normally.
        if (sel_ready_c) begin
          ready   = 1'b1;
          rdata   = write_q ? 32'h0 : sel_rdata_c;
          state_d = IDLE;
        end else if (timeout_c) begin
          ready   = 1'b1;
          err     = 1'b1;
          state_d = IDLE;
        end
      end
      ERROR: begin
        ready   = 1'b1;
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_periph_bus_ctrl.sv
// Self-checking bench for periph_bus_ctrl: directed scenarios plus randomized transfers against an address-range model.
module tb_periph_bus_ctrl;

  localparam int unsigned NS   = 4;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int unsigned TMO  = 16;

  logic            clk;
  logic            reset;
  logic            transfer;
  logic            write;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic [31:0]     rdata;
  logic            ready;
  logic            err;
  logic [3:0]      p_addr;
  logic            p_wr_en;
  logic [31:0]     p_wdata;
  logic            p_enable;
  logic [NS-1:0]   p_ce;
  logic [32*NS-1:0] p_rdata;
  logic [NS-1:0]   p_ready;

  int total = 0;
  int bad   = 0;

  periph_bus_ctrl #(
    .NUM_SLAVES(NS),
    .BASE_ADDR(BASE),
    .SLOT_BITS(12),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .transfer(transfer), .write(write), .addr(addr),
    .wdata(wdata), .rdata(rdata), .ready(ready), .err(err), .p_addr(p_addr),
    .p_wr_en(p_wr_en), .p_wdata(p_wdata), .p_enable(p_enable), .p_ce(p_ce),
    .p_rdata(p_rdata), .p_ready(p_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode: the peripheral window is a contiguous range of NS 4 KiB slots.
  function automatic bit m_hit(input logic [31:0] a);
    longint unsigned off;
    if (a < BASE) return 1'b0;
    off = longint'(a) - longint'(BASE);
    return off < longint'(NS) * 4096;
  endfunction

  function automatic int m_slot(input logic [31:0] a);
    return int'((a - BASE) / 4096);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0;
    p_rdata = '0; p_ready = '0;
    tick(); tick();
    @(negedge clk);
    total++;
    if ({rdata, ready, err, p_addr, p_wr_en, p_wdata, p_enable, p_ce} !== '0) begin
      bad++;
      $display("FAIL reset_held got rdy=%0b err=%0b ce=%b en=%0b rdata=%h want all zero", ready, err, p_ce, p_enable, rdata);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({rdata, ready, err, p_addr, p_wr_en, p_wdata, p_enable, p_ce} !== '0) begin
      bad++;
      $display("FAIL reset_release got rdy=%0b ce=%b want all zero", ready, p_ce);
    end
  endtask

  task automatic test_read_hit();
    tick();
    transfer = 1'b1; write = 1'b0; addr = 32'h1000_0000; wdata = '0;
    p_rdata = '0; p_rdata[31:0] = 32'h0000_000A; p_ready = 4'b0001;
    @(negedge clk);
    total++;
    if (ready !== 1'b0 || p_ce !== 4'b0000) begin
      bad++; $display("FAIL rd_c0 got rdy=%0b ce=%b want rdy=0 ce=0000", ready, p_ce);
    end
    tick();
    @(negedge clk);
    total++;
    if (p_ce !== 4'b0001 || p_enable !== 1'b0 || ready !== 1'b0) begin
      bad++; $display("FAIL rd_setup got ce=%b en=%0b rdy=%0b want ce=0001 en=0 rdy=0", p_ce, p_enable, ready);
    end
    tick();
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || err !== 1'b0 || rdata !== 32'h0000_000A || p_enable !== 1'b1) begin
      bad++; $display("FAIL rd_access got rdy=%0b err=%0b rdata=%h en=%0b want 1 0 0000000a 1", ready, err, rdata, p_enable);
    end
    tick();
    transfer = 1'b0; p_ready = '0;
    @(negedge clk);
    total++;
    if (ready !== 1'b0 || p_ce !== 4'b0000) begin
      bad++; $display("FAIL rd_after got rdy=%0b ce=%b want 0 0000", ready, p_ce);
    end
  endtask

  task automatic test_write_wait();
    logic [3:0] exp_ce;
    for (int c = 0; c <= 6; c++) begin
      tick();
      if (c == 0) begin
        transfer = 1'b1; write = 1'b1; addr = 32'h1000_1008; wdata = 32'hDEAD_BEEF;
        p_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
      if (c == 6) transfer = 1'b0;
      p_ready = 4'($urandom);
      p_ready[1] = (c >= 5);
      @(negedge clk);
      exp_ce = (c >= 1 && c <= 5) ? 4'b0010 : 4'b0000;
      total++;
      if (ready !== (c == 5) || p_ce !== exp_ce || p_enable !== (c >= 2 && c <= 5)) begin
        bad++;
        $display("FAIL wr_wait_c%0d got rdy=%0b ce=%b en=%0b want rdy=%0b ce=%b", c, ready, p_ce, p_enable, (c == 5), exp_ce);
      end
      if (c >= 1 && c <= 5) begin
        total++;
        if (p_addr !== 4'h2 || p_wr_en !== 1'b1 || p_wdata !== 32'hDEAD_BEEF) begin
          bad++;
          $display("FAIL wr_bus_c%0d got a=%h we=%0b wd=%h want 2 1 deadbeef", c, p_addr, p_wr_en, p_wdata);
        end
      end
      if (c == 5) begin
        total++;
        if (err !== 1'b0 || rdata !== 32'h0) begin
          bad++; $display("FAIL wr_resp got err=%0b rdata=%h want 0 0", err, rdata);
        end
      end
    end
  endtask

  task automatic test_decode_miss();
    logic [31:0] miss_addr [2];
    miss_addr[0] = 32'h2000_0000;
    miss_addr[1] = 32'h1000_4000;
    for (int k = 0; k < 2; k++) begin
      tick();
      transfer = 1'b1; write = 1'b0; addr = miss_addr[k];
      p_rdata = {$urandom, $urandom, $urandom, $urandom}; p_ready = '1;
      @(negedge clk);
      total++;
      if (ready !== 1'b0 || p_ce !== '0) begin
        bad++; $display("FAIL miss%0d_c0 got rdy=%0b ce=%b want 0 0000", k, ready, p_ce);
      end
      tick();
      @(negedge clk);
      total++;
      if (ready !== 1'b1 || err !== 1'b1 || rdata !== 32'h0 || p_ce !== '0 || p_enable !== 1'b0) begin
        bad++;
        $display("FAIL miss%0d_c1 got rdy=%0b err=%0b rdata=%h ce=%b en=%0b want 1 1 0 0000 0", k, ready, err, rdata, p_ce, p_enable);
      end
      tick();
      transfer = 1'b0;
      @(negedge clk);
      total++;
      if (ready !== 1'b0 || p_ce !== '0) begin
        bad++; $display("FAIL miss%0d_c2 got rdy=%0b ce=%b want 0 0000", k, ready, p_ce);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r2, r3, exp_rd;
    logic [3:0]  exp_ce;
    r2 = $urandom; r3 = $urandom;
    for (int c = 0; c <= 6; c++) begin
      tick();
      if (c == 0) begin
        transfer = 1'b1; write = 1'b0; addr = 32'h1000_2004;
        p_rdata = {r3, r2, 32'($urandom), 32'($urandom)}; p_ready = 4'b1100;
      end
      if (c == 3) addr = 32'h1000_3008;
      if (c == 6) transfer = 1'b0;
      @(negedge clk);
      exp_ce = (c == 1 || c == 2) ? 4'b0100 : (c == 4 || c == 5) ? 4'b1000 : 4'b0000;
      exp_rd = (c == 2) ? r2 : (c == 5) ? r3 : 32'h0;
      total++;
      if (ready !== (c == 2 || c == 5) || p_ce !== exp_ce || rdata !== exp_rd || $countones(p_ce) > 1) begin
        bad++;
        $display("FAIL b2b_c%0d got rdy=%0b ce=%b rdata=%h want rdy=%0b ce=%b rdata=%h", c, ready, p_ce, rdata, (c == 2 || c == 5), exp_ce, exp_rd);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c <= 8; c++) begin
      tick();
      case (c)
        0: begin
          transfer = 1'b1; write = 1'b1; addr = 32'h1000_003C; wdata = $urandom | 32'h1;
          p_ready = 4'b0000;
        end
        3: reset = 1'b1;
        4: begin reset = 1'b0; transfer = 1'b0; end
        6: begin transfer = 1'b1; write = 1'b0; addr = BASE; p_ready = 4'b0001; end
        8: transfer = 1'b0;
        default: ;
      endcase
      @(negedge clk);
      if (c == 2 || c == 3) begin
        total++;
        if (ready !== 1'b0 || p_enable !== 1'b1 || p_ce !== 4'b0001) begin
          bad++; $display("FAIL rstmid_stall_c%0d got rdy=%0b en=%0b ce=%b want 0 1 0001", c, ready, p_enable, p_ce);
        end
      end
      if (c == 4 || c == 5) begin
        total++;
        if ({rdata, ready, err, p_addr, p_wr_en, p_wdata, p_enable, p_ce} !== '0) begin
          bad++;
          $display("FAIL rstmid_zero_c%0d got rdy=%0b ce=%b en=%0b we=%0b a=%h wd=%h want all zero", c, ready, p_ce, p_enable, p_wr_en, p_addr, p_wdata);
        end
      end
      if (c == 7 || c == 8) begin
        total++;
        if (ready !== (c == 8) || p_ce !== 4'b0001) begin
          bad++; $display("FAIL rstmid_recover_c%0d got rdy=%0b ce=%b want rdy=%0b ce=0001", c, ready, p_ce, (c == 8));
        end
      end
    end
  endtask

  task automatic test_timeout();
    tick();
    transfer = 1'b1; write = 1'b0; addr = BASE; p_ready = 4'b0000;
    p_rdata = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
`ifdef PERIPH_BUS_TIMEOUT_EN
    for (int c = 1; c <= TMO + 2; c++) begin
      tick();
      if (c == TMO + 2) transfer = 1'b0;
      p_ready = 4'($urandom) & 4'b1110;
      @(negedge clk);
      total++;
      if (ready !== (c == TMO + 1) || p_ce !== ((c <= TMO + 1) ? 4'b0001 : 4'b0000) ||
          (c == TMO + 1 && (err !== 1'b1 || rdata !== 32'h0))) begin
        bad++;
        $display("FAIL timeout_c%0d got rdy=%0b err=%0b ce=%b rdata=%h", c, ready, err, p_ce, rdata);
      end
    end
`else
    for (int c = 1; c <= 100; c++) begin
      tick();
      p_ready = 4'($urandom) & 4'b1110;
      @(negedge clk);
      total++;
      if (ready !== 1'b0 || p_ce !== 4'b0001) begin
        bad++; $display("FAIL no_timeout_c%0d got rdy=%0b ce=%b want 0 0001", c, ready, p_ce);
      end
    end
    tick();
    reset = 1'b1; transfer = 1'b0;
    tick();
    reset = 1'b0;
`endif
    p_ready = '0;
  endtask

  task automatic test_random();
    logic [31:0]      a, wd, exp_rd;
    logic [32*NS-1:0] prd;
    logic [NS-1:0]    exp_ce;
    bit               hit, wr, done;
    int               slot, w, kind, c;
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 3);
      if (kind <= 1)      a = BASE + $urandom_range(0, NS * 4096 - 1);
      else if (kind == 2) a = BASE + NS * 4096 + $urandom_range(0, 32'h7FFF - NS * 4096);
      else                a = $urandom;
      hit  = m_hit(a);
      slot = hit ? m_slot(a) : 0;
      w    = $urandom_range(0, 4);
      wr   = 1'($urandom_range(0, 1));
      wd   = $urandom;
      prd  = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        tick();
        transfer = 1'b0; p_ready = 4'($urandom);
        @(negedge clk);
        total++;
        if (ready !== 1'b0 || p_ce !== '0) begin
          bad++; $display("FAIL rand%0d_gap got rdy=%0b ce=%b want 0 0", t, ready, p_ce);
        end
      end
      done = 1'b0;
      c = 0;
      while (!done) begin
        tick();
        if (c == 0) begin
          transfer = 1'b1; write = wr; addr = a; wdata = wd; p_rdata = prd;
        end
        p_ready = 4'($urandom);
        if (hit) p_ready[slot] = (c >= 2 + w);
        @(negedge clk);
        if (hit) begin
          done   = (c == 2 + w);
          exp_ce = (c >= 1) ? (NS'(1) << slot) : '0;
          exp_rd = (done && !wr) ? prd[32*slot +: 32] : 32'h0;
          total++;
          if ({ready, err, p_enable, p_ce, rdata} !== {done, 1'b0, (c >= 2), exp_ce, exp_rd}) begin
            bad++;
            $display("FAIL rand%0d_c%0d a=%h got rdy=%0b err=%0b en=%0b ce=%b rd=%h want %0b 0 %0b %b %h", t, c, a, ready, err, p_enable, p_ce, rdata, done, (c >= 2), exp_ce, exp_rd);
          end
          if (c >= 1) begin
            total++;
            if (p_addr !== a[5:2] || p_wr_en !== wr || p_wdata !== wd) begin
              bad++;
              $display("FAIL rand%0d_bus_c%0d got a=%h we=%0b wd=%h want %h %0b %h", t, c, p_addr, p_wr_en, p_wdata, a[5:2], wr, wd);
            end
          end
        end else begin
          done = (c == 1);
          total++;
          if ({ready, err, p_enable, p_ce, rdata} !== {done, done, 1'b0, NS'(0), 32'h0}) begin
            bad++;
            $display("FAIL rand%0d_miss_c%0d a=%h got rdy=%0b err=%0b ce=%b rd=%h want rdy=err=%0b", t, c, a, ready, err, p_ce, rdata, done);
          end
        end
        c++;
      end
    end
    tick();
    transfer = 1'b0; p_ready = '0;
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_write_wait();
    test_decode_miss();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    test_random();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
